// File: rtl/uvmt_cvmcu_probe_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : uvmt_cvmcu_probe_arbiter
// Brief    : Round-robin arbiter sharing one probe capture channel between
//            N_REQ probe groups, with timestamping and a drain FIFO.
// Revision : 1.0 - initial release
// ============================================================================
module uvmt_cvmcu_probe_arbiter #(
    parameter  int N_REQ  = 4,
    parameter  int DATA_W = 32,
    parameter  int DEPTH  = 8,
    parameter  int TS_W   = 32,
    localparam int SRC_W  = $clog2(N_REQ),
    localparam int LVL_W  = $clog2(DEPTH) + 1
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    enable_i,
    input  logic [N_REQ-1:0]        req_i,
    input  logic [N_REQ*DATA_W-1:0] data_i,
    output logic [N_REQ-1:0]        gnt_o,
    output logic                    out_valid_o,
    input  logic                    out_ready_i,
    output logic [DATA_W-1:0]       out_data_o,
    output logic [SRC_W-1:0]        out_src_o,
    output logic [TS_W-1:0]         out_ts_o,
    output logic [LVL_W-1:0]        level_o,
    output logic [15:0]             stall_cnt_o
);

    localparam int                PTR_W   = $clog2(DEPTH);
    localparam logic [SRC_W:0]    c_n_req = (SRC_W+1)'(N_REQ);
    localparam logic [LVL_W-1:0]  c_depth = LVL_W'(DEPTH);

    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [LVL_W-1:0]  r_level;
    logic [SRC_W-1:0]  r_rr_ptr;
    logic [TS_W-1:0]   r_ts;
    logic [15:0]       r_stall;

    logic [DATA_W-1:0] r_mem_data [DEPTH];
    logic [SRC_W-1:0]  r_mem_src  [DEPTH];
    logic [TS_W-1:0]   r_mem_ts   [DEPTH];

    logic [DATA_W-1:0] w_data_arr [N_REQ];
    logic              w_can_grant;
    logic              w_found;
    logic [SRC_W:0]    w_probe;
    logic [SRC_W-1:0]  w_gnt_idx;
    logic [SRC_W-1:0]  w_rr_next;
    logic              w_push;
    logic              w_pop;
    logic              w_stall_evt;

    generate
        for (genvar k = 0; k < N_REQ; k++) begin : g_unpack
            assign w_data_arr[k] = data_i[k*DATA_W +: DATA_W];
        end
    endgenerate

    // Fullness uses the registered level only, so a same-cycle pop never
    // opens a slot for the grant in that cycle.
    always_comb begin
        w_can_grant = enable_i && (r_level < c_depth);
        w_found     = 1'b0;
        w_gnt_idx   = '0;
        w_probe     = '0;
        for (int i = 0; i < N_REQ; i++) begin
            w_probe = {1'b0, r_rr_ptr} + (SRC_W+1)'(i);
            if (w_probe >= c_n_req) begin
                w_probe = w_probe - c_n_req;
            end
            if (!w_found && req_i[w_probe[SRC_W-1:0]]) begin
                w_found   = 1'b1;
                w_gnt_idx = w_probe[SRC_W-1:0];
            end
        end
        w_push    = reset_n && w_can_grant && w_found;
        w_rr_next = (w_gnt_idx == SRC_W'(N_REQ-1)) ? '0 : w_gnt_idx + SRC_W'(1);
    end

    assign gnt_o       = w_push ? (N_REQ'(1) << w_gnt_idx) : '0;
    assign out_valid_o = (r_level != '0);
    assign w_pop       = out_valid_o && out_ready_i;
    assign w_stall_evt = (|req_i) && enable_i && (r_level == c_depth);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
            r_rr_ptr <= '0;
            r_ts     <= '0;
            r_stall  <= '0;
        end else begin
            r_ts <= r_ts + TS_W'(1);
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
                r_rr_ptr <= w_rr_next;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + LVL_W'(1);
                2'b01:   r_level <= r_level - LVL_W'(1);
                default: r_level <= r_level;
            endcase
            if (w_stall_evt && (r_stall != 16'hFFFF)) begin
                r_stall <= r_stall + 16'd1;
            end
        end
    end

    // Storage carries no reset; contents are meaningless while level is 0.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_data[r_wr_ptr] <= w_data_arr[w_gnt_idx];
            r_mem_src[r_wr_ptr]  <= w_gnt_idx;
            r_mem_ts[r_wr_ptr]   <= r_ts;
        end
    end

    assign out_data_o  = r_mem_data[r_rd_ptr];
    assign out_src_o   = r_mem_src[r_rd_ptr];
    assign out_ts_o    = r_mem_ts[r_rd_ptr];
    assign level_o     = r_level;
    assign stall_cnt_o = r_stall;

endmodule
`default_nettype wire

// File: tb/tb_uvmt_cvmcu_probe_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_uvmt_cvmcu_probe_arbiter
// Brief    : Self-checking bench: queue-based reference model plus directed
//            vectors with hand-computed expectations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uvmt_cvmcu_probe_arbiter;

    localparam int N_REQ  = 4;
    localparam int DATA_W = 32;
    localparam int DEPTH  = 8;
    localparam int TS_W   = 32;

    logic                    clk = 1'b0;
    logic                    reset_n;
    logic                    enable_i;
    logic [N_REQ-1:0]        req_i;
    logic [N_REQ*DATA_W-1:0] data_i;
    logic [N_REQ-1:0]        gnt_o;
    logic                    out_valid_o;
    logic                    out_ready_i;
    logic [DATA_W-1:0]       out_data_o;
    logic [1:0]              out_src_o;
    logic [TS_W-1:0]         out_ts_o;
    logic [3:0]              level_o;
    logic [15:0]             stall_cnt_o;

    uvmt_cvmcu_probe_arbiter #(
        .N_REQ (N_REQ),
        .DATA_W(DATA_W),
        .DEPTH (DEPTH),
        .TS_W  (TS_W)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .enable_i   (enable_i),
        .req_i      (req_i),
        .data_i     (data_i),
        .gnt_o      (gnt_o),
        .out_valid_o(out_valid_o),
        .out_ready_i(out_ready_i),
        .out_data_o (out_data_o),
        .out_src_o  (out_src_o),
        .out_ts_o   (out_ts_o),
        .level_o    (level_o),
        .stall_cnt_o(stall_cnt_o)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: samples as a plain queue, pointer as an integer.
    typedef struct {
        logic [31:0] d;
        int          s;
        logic [31:0] t;
    } samp_t;

    samp_t       m_q[$];
    int          m_rr    = 0;
    logic [31:0] m_ts    = 0;
    int          m_stall = 0;
    bit          m_init  = 0;

    function automatic logic [N_REQ-1:0] exp_gnt();
        if (!reset_n || !enable_i || m_q.size() >= DEPTH || req_i == '0) return '0;
        for (int i = 0; i < N_REQ; i++) begin
            int idx;
            idx = (m_rr + i) % N_REQ;
            if (req_i[idx]) return N_REQ'(1) << idx;
        end
        return '0;
    endfunction

    always @(posedge clk) begin
        if (!reset_n) begin
            m_q.delete();
            m_rr    = 0;
            m_ts    = 0;
            m_stall = 0;
            m_init  = 1;
        end else if (m_init) begin
            logic [N_REQ-1:0] g;
            bit               was_full;
            g        = exp_gnt();
            was_full = (m_q.size() == DEPTH);
            if ((req_i != '0) && enable_i && was_full && m_stall < 65535) m_stall++;
            if (m_q.size() != 0 && out_ready_i) void'(m_q.pop_front());
            for (int k = 0; k < N_REQ; k++) begin
                if (g[k]) begin
                    samp_t s;
                    s.d = data_i[k*DATA_W +: DATA_W];
                    s.s = k;
                    s.t = m_ts;
                    m_q.push_back(s);
                    m_rr = (k + 1) % N_REQ;
                end
            end
            m_ts = m_ts + 1;
        end
    end

    always @(negedge clk) begin
        if (!reset_n) begin
            check("gnt_in_reset", gnt_o, '0);
        end else if (m_init) begin
            check("gnt", gnt_o, exp_gnt());
            check("valid", out_valid_o, m_q.size() != 0);
            check("level", level_o, m_q.size());
            check("stall", stall_cnt_o, m_stall);
            if (m_q.size() != 0) begin
                check("head_data", out_data_o, m_q[0].d);
                check("head_src", out_src_o, m_q[0].s);
                check("head_ts", out_ts_o, m_q[0].t);
            end
        end
    end

    task automatic drive(input bit rn, input bit en, input logic [3:0] rq,
                         input logic [31:0] d0, input bit rdy);
        reset_n     = rn;
        enable_i    = en;
        req_i       = rq;
        data_i      = {d0 + 32'd3, d0 + 32'd2, d0 + 32'd1, d0};
        out_ready_i = rdy;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    initial begin
        drive(0, 0, 4'b0000, 32'h0, 0);
        nxt();
        nxt();

        // Single capture: latency 1, stamped with ts=0 (first cycle after reset)
        drive(1, 1, 4'b0001, 32'hA5, 0);
        mid(); check("t1_gnt", gnt_o, 4'b0001);
        nxt();
        drive(1, 1, 4'b0000, 32'h0, 0);
        mid();
        check("t1_valid", out_valid_o, 1'b1);
        check("t1_data", out_data_o, 32'hA5);
        check("t1_src", out_src_o, 2'd0);
        check("t1_ts", out_ts_o, 32'd0);
        check("t1_level", level_o, 4'd1);
        nxt();

        // Round-robin rotation from rr_ptr=0
        drive(0, 0, 4'b0000, 32'h0, 0);
        nxt();
        for (int i = 0; i < 8; i++) begin
            drive(1, 1, 4'b1111, 32'h100 + 32'(i * 16), 1);
            mid(); check("t2_gnt", gnt_o, 4'b0001 << (i % 4));
            nxt();
        end

        // Fill, stall counting, pop without same-cycle grant
        drive(0, 0, 4'b0000, 32'h0, 0);
        nxt();
        for (int i = 0; i < 8; i++) begin
            drive(1, 1, 4'b0100, 32'h200 + 32'(i * 16), 0);
            mid(); check("t3_gnt_fill", gnt_o, 4'b0100);
            nxt();
        end
        for (int i = 0; i < 3; i++) begin
            drive(1, 1, 4'b0100, 32'h2F0, 0);
            mid();
            check("t3_gnt_full", gnt_o, 4'b0000);
            check("t3_level_full", level_o, 4'd8);
            check("t3_stall", stall_cnt_o, 16'(i));
            nxt();
        end
        drive(1, 1, 4'b0100, 32'h2F0, 1);
        mid();
        check("t3_gnt_pop", gnt_o, 4'b0000);
        check("t3_stall_pop", stall_cnt_o, 16'd3);
        nxt();
        drive(1, 1, 4'b0100, 32'h2E0, 0);
        mid();
        check("t3_gnt_resume", gnt_o, 4'b0100);
        check("t3_level_resume", level_o, 4'd7);
        nxt();

        // Full FIFO draining while requests keep arriving
        for (int i = 0; i < 24; i++) begin
            drive(1, 1, (i < 12) ? 4'b0100 : 4'b1111, 32'h300 + 32'(i * 16), 1);
            mid();
            if (i < 12) check("t4_level_band", level_o >= 4'd7, 1'b1);
            nxt();
        end
        for (int i = 0; i < 10; i++) begin
            drive(1, 1, 4'b0000, 32'h0, 1);
            mid();
            nxt();
        end

        // enable_i low: drain only, no grants, stall frozen
        drive(0, 0, 4'b0000, 32'h0, 0);
        nxt();
        for (int i = 0; i < 3; i++) begin
            drive(1, 1, 4'b0001, 32'h400 + 32'(i * 16), 0);
            mid();
            nxt();
        end
        for (int i = 0; i < 3; i++) begin
            drive(1, 0, 4'b0011, 32'h500, 1);
            mid();
            check("t5_gnt_off", gnt_o, 4'b0000);
            check("t5_level", level_o, 4'(3 - i));
            check("t5_stall", stall_cnt_o, 16'd0);
            nxt();
        end
        drive(1, 0, 4'b0011, 32'h500, 1);
        mid();
        check("t5_empty", out_valid_o, 1'b0);
        check("t5_level0", level_o, 4'd0);
        nxt();
        drive(1, 1, 4'b0011, 32'h510, 1);
        mid(); check("t5_gnt_rr", gnt_o, 4'b0010);
        nxt();

        // Mid-operation reset with level 5
        drive(0, 0, 4'b0000, 32'h0, 0);
        nxt();
        for (int i = 0; i < 10; i++) begin
            drive(1, 1, 4'b0001, 32'h600 + 32'(i * 16), 0);
            mid();
            nxt();
        end
        for (int i = 0; i < 3; i++) begin
            drive(1, 1, 4'b0000, 32'h0, 1);
            mid();
            nxt();
        end
        drive(0, 1, 4'b1111, 32'h700, 1);
        mid();
        check("t6_rst_gnt", gnt_o, 4'b0000);
        check("t6_pre_level", level_o, 4'd5);
        check("t6_pre_stall", stall_cnt_o, 16'd2);
        nxt();
        drive(1, 1, 4'b1010, 32'h710, 0);
        mid();
        check("t6_level", level_o, 4'd0);
        check("t6_valid", out_valid_o, 1'b0);
        check("t6_stall", stall_cnt_o, 16'd0);
        check("t6_gnt", gnt_o, 4'b0010);
        nxt();
        drive(1, 1, 4'b0000, 32'h0, 0);
        mid();
        check("t6_ts", out_ts_o, 32'd0);
        check("t6_src", out_src_o, 2'd1);
        check("t6_data", out_data_o, 32'h711);
        nxt();

        for (int i = 0; i < 3; i++) begin
            drive(1, 1, 4'b0000, 32'h0, 1);
            mid();
            nxt();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
